// File: rtl/dpfifo_pkg.sv
// rtl/dpfifo_pkg.sv - shared widths, depth and pointer/count types for the dual-port RAM FIFO
package dpfifo_pkg;

    localparam int DPFIFO_DW = 8;
    localparam int DPFIFO_AW = 6;
    localparam int DEPTH     = 1 << DPFIFO_AW;

    typedef logic [DPFIFO_AW-1:0] ptr_t;
    typedef logic [DPFIFO_AW:0]   cnt_t;
    typedef logic [DPFIFO_AW+1:0] level_t;

endpackage

// File: rtl/dpfifo_skid2.sv
// rtl/dpfifo_skid2.sv - 2-entry output buffer absorbing the RAM read latency; entry 0 is the head
module dpfifo_skid2
    import dpfifo_pkg::*;
#(
    parameter int DW = DPFIFO_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic [1:0]    cnt,
    output logic          valid
);

    logic [DW-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          valid_q, valid_d;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        if (rd_en) begin
            if (cnt_q == 2'd2) begin
                ent0_d = ent1_q;
                if (wr_en) ent1_d = wr_data;
            end else if (wr_en) begin
                ent0_d = wr_data;
            end
        end else if (wr_en) begin
            if (cnt_q == 2'd0) ent0_d = wr_data;
            else               ent1_d = wr_data;
        end
        cnt_d   = cnt_q + 2'(wr_en) - 2'(rd_en);
        valid_d = (cnt_d != 2'd0);
    end

    // Head is left untouched when the buffer drains so the output holds its last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign rd_data = ent0_q;
    assign cnt     = cnt_q;
    assign valid   = valid_q;

endmodule

// File: rtl/true_dpram_sclk.sv
// rtl/true_dpram_sclk.sv - single-clock true dual-port RAM with registered read data on both ports
module true_dpram_sclk
    import dpfifo_pkg::*;
#(
    parameter int DW = DPFIFO_DW,
    parameter int AW = DPFIFO_AW
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] data_a,
    input  logic          we_a,
    output logic [DW-1:0] q_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] data_b,
    input  logic          we_b,
    output logic [DW-1:0] q_b
);

    logic [DW-1:0] mem [1 << AW];

    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= data_a;
        if (we_b) mem[addr_b] <= data_b;
        q_a <= mem[addr_a];
        q_b <= mem[addr_b];
    end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// rtl/dpram_fifo_ctrl.sv - valid/ready FIFO controller driving an external true_dpram_sclk
// almost_full/almost_empty flags exist only when DPFIFO_FLAGS_EN is defined.
module dpram_fifo_ctrl
    import dpfifo_pkg::*;
#(
    parameter int DW = DPFIFO_DW,
    parameter int AW = DPFIFO_AW
`ifdef DPFIFO_FLAGS_EN
    ,
    parameter int AF_THRESH = 56,
    parameter int AE_THRESH = 4
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [AW+1:0] level,
    output logic [AW-1:0] ram_addr_a,
    output logic [DW-1:0] ram_data_a,
    output logic          ram_we_a,
    output logic [AW-1:0] ram_addr_b,
    output logic [DW-1:0] ram_data_b,
    output logic          ram_we_b,
    input  logic [DW-1:0] ram_q_b
`ifdef DPFIFO_FLAGS_EN
    ,
    output logic          almost_full,
    output logic          almost_empty
`endif
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(1 << AW);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   ram_cnt_q, ram_cnt_d;
    logic          rd_pending_q, rd_pending_d;
    logic          s_ready_q, s_ready_d;
    logic          push, pop, rd_go;
    logic [1:0]    skid_cnt;
    logic          skid_valid;

    // A read is issued only when its word is guaranteed a skid slot on arrival.
    always_comb begin
        push         = s_valid & s_ready_q;
        pop          = skid_valid & m_ready;
        rd_go        = (ram_cnt_q != '0) &&
                       (({1'b0, skid_cnt} + {2'b00, rd_pending_q}) < (3'd2 + {2'b00, pop}));
        wr_ptr_d     = wr_ptr_q + AW'(push);
        rd_ptr_d     = rd_ptr_q + AW'(rd_go);
        ram_cnt_d    = ram_cnt_q + (AW+1)'(push) - (AW+1)'(rd_go);
        rd_pending_d = rd_go;
        s_ready_d    = (ram_cnt_d < CNT_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ram_cnt_q    <= '0;
            rd_pending_q <= 1'b0;
            s_ready_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ram_cnt_q    <= ram_cnt_d;
            rd_pending_q <= rd_pending_d;
            s_ready_q    <= s_ready_d;
        end
    end

    dpfifo_skid2 #(.DW(DW)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (rd_pending_q),
        .wr_data (ram_q_b),
        .rd_en   (pop),
        .rd_data (m_data),
        .cnt     (skid_cnt),
        .valid   (skid_valid)
    );

    assign s_ready    = s_ready_q;
    assign m_valid    = skid_valid;
    assign level      = (AW+2)'(ram_cnt_q) + (AW+2)'(rd_pending_q) + (AW+2)'(skid_cnt);
    assign ram_addr_a = wr_ptr_q;
    assign ram_data_a = s_data;
    assign ram_we_a   = push;
    assign ram_addr_b = rd_ptr_q;
    assign ram_data_b = '0;
    assign ram_we_b   = 1'b0;

`ifdef DPFIFO_FLAGS_EN
    localparam logic [AW+1:0] AF_LVL = (AW+2)'(AF_THRESH);
    localparam logic [AW+1:0] AE_LVL = (AW+2)'(AE_THRESH);

    logic [AW+1:0] level_d;
    logic          almost_full_q, almost_full_d, almost_empty_q, almost_empty_d;

    always_comb begin
        level_d        = level + (AW+2)'(push) - (AW+2)'(pop);
        almost_full_d  = (level_d >= AF_LVL);
        almost_empty_d = (level_d <= AE_LVL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
`endif

endmodule
